// File: rtl/boot_loader.sv
// Byte-stream program loader: writes a framed image into memory, verifies
// its checksum and then releases the CPU core from reset.
//
// Ports:
//   clk, rst_n        clock and synchronous active-low reset
//   rx_valid/rx_data  incoming byte stream, rx_ready accepts it
//   mem_wr/addr/wdata one-cycle write strobe with address and data
//   cpu_rst_n         CPU reset, released only after a verified load
//   load_done         image loaded and verified
//   load_err          last frame failed
module boot_loader #(
  parameter logic [12:0] BASE_ADDR      = 13'h0000,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        mem_wr,
  output logic [12:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        cpu_rst_n,
  output logic        load_done,
  output logic        load_err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_HI = 3'd1;
  localparam logic [2:0] S_LEN_LO = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_CSUM   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;

  logic [2:0]  state;
  logic [4:0]  len_hi;
  logic [12:0] len;
  logic [12:0] cnt;
  logic [7:0]  sum;
  logic [15:0] tmo;

  logic acc;
  logic in_frame;
  logic tmo_hit;
  logic [12:0] len_new;

  assign acc      = rx_valid && rx_ready;
  assign in_frame = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                    (state == S_DATA)   || (state == S_CSUM);
  // Fires on the idle cycle that would bring the count to the limit.
  assign tmo_hit  = (TIMEOUT_CYCLES != 16'd0) &&
                    (tmo == TIMEOUT_CYCLES - 16'd1);
  assign len_new  = {len_hi, rx_data};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      len_hi    <= '0;
      len       <= '0;
      cnt       <= '0;
      sum       <= '0;
      tmo       <= '0;
      rx_ready  <= 1'b1;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rst_n <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      mem_wr <= 1'b0;
      if (acc) begin
        tmo <= '0;
      end else if (in_frame) begin
        tmo <= tmo + 16'd1;
      end
      if (acc) begin
        case (state)
          S_IDLE, S_ERR: begin
            if (rx_data == SYNC_BYTE) begin
              state    <= S_LEN_HI;
              load_err <= 1'b0;
            end
          end
          S_LEN_HI: begin
            if (rx_data[7:5] != 3'd0) begin
              state    <= S_ERR;
              load_err <= 1'b1;
            end else begin
              len_hi <= rx_data[4:0];
              state  <= S_LEN_LO;
            end
          end
          S_LEN_LO: begin
            len   <= len_new;
            cnt   <= '0;
            sum   <= '0;
            state <= (len_new == 13'd0) ? S_CSUM : S_DATA;
          end
          S_DATA: begin
            mem_wr    <= 1'b1;
            mem_addr  <= BASE_ADDR + cnt;
            mem_wdata <= rx_data;
            sum       <= sum + rx_data;
            cnt       <= cnt + 13'd1;
            if (cnt == len - 13'd1) begin
              state <= S_CSUM;
            end
          end
          S_CSUM: begin
            if (rx_data == sum) begin
              state     <= S_DONE;
              rx_ready  <= 1'b0;
              cpu_rst_n <= 1'b1;
              load_done <= 1'b1;
            end else begin
              state    <= S_ERR;
              load_err <= 1'b1;
            end
          end
          default: ;
        endcase
      end else if (in_frame && tmo_hit) begin
        state    <= S_ERR;
        load_err <= 1'b1;
        tmo      <= '0;
      end
    end
  end

endmodule
